// File: rtl/akiko_c2p_dma_pkg.sv
// Shared definitions for the Akiko chunky-to-planar DMA: register map, CTRL bits, FSM encoding.
package akiko_c2p_dma_pkg;

   localparam logic [7:0] RegSrcH  = 8'h40;
   localparam logic [7:0] RegSrcL  = 8'h42;
   localparam logic [7:0] RegDstH  = 8'h44;
   localparam logic [7:0] RegDstL  = 8'h46;
   localparam logic [7:0] RegPmod  = 8'h48;
   localparam logic [7:0] RegCount = 8'h4A;
   localparam logic [7:0] RegCtrl  = 8'h4C;

   localparam int unsigned CtrlStart  = 0;
   localparam int unsigned CtrlAbort  = 1;
   localparam int unsigned CtrlClrIrq = 2;
   localparam int unsigned CtrlIrq    = 14;
   localparam int unsigned CtrlBusy   = 15;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StFetch = 3'd1,
      StPush  = 3'd2,
      StPull  = 3'd3,
      StStore = 3'd4,
      StNext  = 3'd5,
      StDone  = 3'd6
   } state_e;

endpackage

// File: rtl/c2p_dma_regs.sv
// CPU register decode and register file; addresses and PMOD are kept as word quantities.
module c2p_dma_regs (
   input  logic        clk,
   input  logic        _reset,
   input  logic        clk7_en,
   input  logic [7:1]  reg_addr,
   input  logic [15:0] data_in,
   input  logic        rd,
   input  logic        sel_c2pdma,
   input  logic        busy,
   input  logic        irq,
   input  logic        advance,
   output logic [15:0] data_out,
   output logic [23:1] src,
   output logic [23:1] dst,
   output logic [15:1] pmod,
   output logic [15:0] count,
   output logic        start,
   output logic        abort,
   output logic        clr_irq
);
   import akiko_c2p_dma_pkg::*;

   logic [23:1] src_q, dst_q;
   logic [15:1] pmod_q;
   logic [15:0] count_q;
   logic [7:0]  offset;
   logic        wr_en, ctrl_wr;

   assign offset  = {reg_addr, 1'b0};
   assign wr_en   = clk7_en & sel_c2pdma & ~rd;
   assign ctrl_wr = wr_en & (offset == RegCtrl);
   assign start   = ctrl_wr & data_in[CtrlStart];
   assign abort   = ctrl_wr & data_in[CtrlAbort];
   assign clr_irq = ctrl_wr & data_in[CtrlClrIrq];

   assign src   = src_q;
   assign dst   = dst_q;
   assign pmod  = pmod_q;
   assign count = count_q;

   // The job advances the working copies in place, so it wins over a CPU write.
   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         src_q   <= '0;
         dst_q   <= '0;
         pmod_q  <= '0;
         count_q <= '0;
      end else if (clk7_en) begin
         if (advance) begin
            src_q   <= src_q + 23'd8;
            dst_q   <= dst_q + 23'd1;
            count_q <= count_q - 16'd1;
         end else if (wr_en) begin
            case (offset)
               RegSrcH:  src_q[23:16] <= data_in[7:0];
               RegSrcL:  src_q[15:1]  <= data_in[15:1];
               RegDstH:  dst_q[23:16] <= data_in[7:0];
               RegDstL:  dst_q[15:1]  <= data_in[15:1];
               RegPmod:  pmod_q       <= data_in[15:1];
               RegCount: count_q      <= data_in;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      data_out = '0;
      if (sel_c2pdma && rd) begin
         case (offset)
            RegSrcH:  data_out = {8'h00, src_q[23:16]};
            RegSrcL:  data_out = {src_q[15:1], 1'b0};
            RegDstH:  data_out = {8'h00, dst_q[23:16]};
            RegDstL:  data_out = {dst_q[15:1], 1'b0};
            RegPmod:  data_out = {pmod_q, 1'b0};
            RegCount: data_out = count_q;
            RegCtrl: begin
               data_out[CtrlBusy] = busy;
               data_out[CtrlIrq]  = irq;
            end
            default: data_out = '0;
         endcase
      end
   end

endmodule

// File: rtl/akiko_c2p_dma.sv
// Akiko C2P DMA: fetches 8 chunky words, pushes them through the C2P unit, stores 8 planes.
module akiko_c2p_dma (
   input  logic        clk,
   input  logic        _reset,
   input  logic        clk7_en,
   input  logic [23:1] address_in,
   input  logic [15:0] data_in,
   input  logic        rd,
   input  logic        sel_c2pdma,
   output logic [15:0] data_out,
   output logic        mem_req,
   output logic        mem_we,
   output logic [23:1] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack,
   output logic        akiko_sel,
   output logic        akiko_rd,
   output logic [15:0] akiko_wdata,
   input  logic [15:0] akiko_rdata,
   output logic        busy,
   output logic        irq
);
   import akiko_c2p_dma_pkg::*;

   state_e      state_q, state_d;
   logic [2:0]  widx_q, widx_d, kidx_q, kidx_d;
   logic [15:0] word_q, word_d;
   logic        abort_pend_q, abort_pend_d, irq_q, irq_d;

   logic [23:1] src, dst, fetch_addr, store_addr, plane_off;
   logic [15:1] pmod;
   logic [15:0] count;
   logic        start, abort, clr_irq, abort_req, in_xfer;
   logic        unused_addr;

   assign unused_addr = ^address_in[23:8];

   c2p_dma_regs u_regs (
      .clk        (clk),
      ._reset     (_reset),
      .clk7_en    (clk7_en),
      .reg_addr   (address_in[7:1]),
      .data_in    (data_in),
      .rd         (rd),
      .sel_c2pdma (sel_c2pdma),
      .busy       (busy),
      .irq        (irq_q),
      .advance    (state_q == StNext),
      .data_out   (data_out),
      .src        (src),
      .dst        (dst),
      .pmod       (pmod),
      .count      (count),
      .start      (start),
      .abort      (abort),
      .clr_irq    (clr_irq)
   );

   // Word-granular arithmetic: wrapping at 2^23 words is wrapping at 2^24 bytes.
   assign plane_off  = {20'd0, 3'd7 - kidx_q} * {8'd0, pmod};
   assign fetch_addr = src + {20'd0, widx_q};
   assign store_addr = dst + plane_off;

   assign busy      = (state_q != StIdle) && (state_q != StDone);
   assign irq       = irq_q;
   assign abort_req = abort | abort_pend_q;
   assign in_xfer   = (state_q == StFetch) || (state_q == StStore);

   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         state_q      <= StIdle;
         widx_q       <= '0;
         kidx_q       <= '0;
         word_q       <= '0;
         abort_pend_q <= 1'b0;
         irq_q        <= 1'b0;
      end else if (clk7_en) begin
         state_q      <= state_d;
         widx_q       <= widx_d;
         kidx_q       <= kidx_d;
         word_q       <= word_d;
         abort_pend_q <= abort_pend_d;
         irq_q        <= irq_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      widx_d       = widx_q;
      kidx_d       = kidx_q;
      word_d       = word_q;
      abort_pend_d = abort_pend_q;
      irq_d        = irq_q;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      akiko_sel    = 1'b0;
      akiko_rd     = 1'b0;
      akiko_wdata  = '0;

      if (clr_irq) irq_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               widx_d  = '0;
               kidx_d  = '0;
               state_d = (count == 16'd0) ? StDone : StFetch;
            end
         end
         StFetch: begin
            mem_req  = 1'b1;
            mem_addr = fetch_addr;
            if (abort) abort_pend_d = 1'b1;
            if (mem_ack) begin
               word_d  = mem_rdata;
               state_d = StPush;
            end
         end
         StPush: begin
            akiko_sel   = 1'b1;
            akiko_wdata = word_q;
            widx_d      = widx_q + 3'd1;
            if (widx_q == 3'd7) begin
               kidx_d  = '0;
               state_d = StPull;
            end else begin
               state_d = StFetch;
            end
         end
         StPull: begin
            akiko_sel = 1'b1;
            akiko_rd  = 1'b1;
            word_d    = akiko_rdata;
            state_d   = StStore;
         end
         StStore: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = store_addr;
            mem_wdata = word_q;
            if (abort) abort_pend_d = 1'b1;
            if (mem_ack) begin
               kidx_d  = kidx_q + 3'd1;
               state_d = (kidx_q == 3'd7) ? StNext : StPull;
            end
         end
         StNext: begin
            widx_d  = '0;
            state_d = (count == 16'd1) ? StDone : StFetch;
         end
         StDone: begin
            if (!abort_req) irq_d = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // A bus transfer in flight is allowed to finish before the abort lands.
      if (abort_req && (state_q != StIdle) && (!in_xfer || mem_ack)) state_d = StIdle;
      if (state_d == StIdle) abort_pend_d = 1'b0;
   end

endmodule

// File: tb/tb_akiko_c2p_dma.sv
// Directed bench for akiko_c2p_dma with a reactive memory and C2P unit model.
module tb_akiko_c2p_dma;

   logic        clk = 1'b0;
   logic        _reset = 1'b0;
   logic        clk7_en = 1'b0;
   logic [23:1] address_in = '0;
   logic [15:0] data_in = '0;
   logic        rd = 1'b1;
   logic        sel_c2pdma = 1'b0;
   logic [15:0] data_out;
   logic        mem_req, mem_we;
   logic [23:1] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;
   logic        akiko_sel, akiko_rd;
   logic [15:0] akiko_wdata;
   logic [15:0] akiko_rdata = '0;
   logic        busy, irq;

   int checks = 0;
   int errors = 0;

   logic [15:0] mem [int];
   logic [15:0] chunky [8];
   int push_cnt = 0, pull_cnt = 0, wcnt = 0, ack_delay = 0;
   int n_rd = 0, n_wr = 0, n_push = 0, n_pull = 0, n_act = 0, stab_err = 0;
   logic        held_valid = 1'b0, held_we = 1'b0;
   logic [23:1] held_addr = '0;
   logic [15:0] held_wdata = '0;

   akiko_c2p_dma dut (
      .clk         (clk),
      ._reset      (_reset),
      .clk7_en     (clk7_en),
      .address_in  (address_in),
      .data_in     (data_in),
      .rd          (rd),
      .sel_c2pdma  (sel_c2pdma),
      .data_out    (data_out),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_ack     (mem_ack),
      .akiko_sel   (akiko_sel),
      .akiko_rd    (akiko_rd),
      .akiko_wdata (akiko_wdata),
      .akiko_rdata (akiko_rdata),
      .busy        (busy),
      .irq         (irq)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] planar(input int p);
      logic [15:0] r;
      logic [7:0]  pix;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         pix = (i % 2 == 0) ? chunky[i / 2][15:8] : chunky[i / 2][7:0];
         r[15 - i] = pix[p];
      end
      return r;
   endfunction

   // Models run just before each enabled edge, on the DUT's settled outputs.
   always @(negedge clk) begin
      clk7_en = ~clk7_en;
      if (!_reset) begin
         mem_ack = 1'b0; wcnt = 0; push_cnt = 0; pull_cnt = 0; held_valid = 1'b0;
      end else if (clk7_en) begin
         if (mem_req || akiko_sel) n_act++;
         if (mem_ack) begin
            mem_ack = 1'b0; wcnt = 0; held_valid = 1'b0;
         end else if (mem_req) begin
            if (held_valid && (mem_addr !== held_addr || mem_we !== held_we ||
                               mem_wdata !== held_wdata)) stab_err++;
            held_valid = 1'b1; held_addr = mem_addr; held_we = mem_we; held_wdata = mem_wdata;
            if (wcnt >= ack_delay) begin
               mem_ack = 1'b1;
               if (mem_we) begin
                  mem[int'(mem_addr)] = mem_wdata; n_wr++;
               end else begin
                  mem_rdata = mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : 16'h0000;
                  n_rd++;
               end
            end else begin
               wcnt++;
            end
         end
         if (akiko_sel && !akiko_rd) begin
            chunky[push_cnt] = akiko_wdata; push_cnt = (push_cnt + 1) % 8; pull_cnt = 0; n_push++;
         end else if (akiko_sel && akiko_rd) begin
            akiko_rdata = planar(7 - pull_cnt); pull_cnt++; n_pull++;
         end
      end
   end

   task automatic step();
      do @(posedge clk); while (!clk7_en);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [7:0] off, input logic [15:0] d);
      logic [23:0] a;
      a = 24'hB80000 | {16'd0, off};
      address_in = a[23:1]; data_in = d; rd = 1'b0; sel_c2pdma = 1'b1;
      step();
      sel_c2pdma = 1'b0; rd = 1'b1;
   endtask

   task automatic chkreg(input string tag, input logic [7:0] off, input logic [15:0] exp);
      logic [23:0] a;
      a = 24'hB80000 | {16'd0, off};
      address_in = a[23:1]; rd = 1'b1; sel_c2pdma = 1'b1;
      #1;
      check(tag, {16'd0, data_out}, {16'd0, exp});
      sel_c2pdma = 1'b0;
   endtask

   task automatic wait_irq(input string tag, input int budget);
      bit ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (irq) begin ok = 1'b1; break; end
         step();
      end
      check(tag, {31'd0, ok}, 32'd1);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      bit ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (!busy) begin ok = 1'b1; break; end
         step();
      end
      check(tag, {31'd0, ok}, 32'd1);
   endtask

   task automatic load_chunky(input int byte_base, input int nwords);
      for (int j = 0; j < nwords; j++) mem[(byte_base >> 1) + j] = {8'(2 * j), 8'(2 * j + 1)};
   endtask

   task automatic setup(input logic [23:0] s, input logic [23:0] d, input logic [15:0] pm,
                        input logic [15:0] cnt);
      wr(8'h40, {8'h00, s[23:16]}); wr(8'h42, s[15:0]);
      wr(8'h44, {8'h00, d[23:16]}); wr(8'h46, d[15:0]);
      wr(8'h48, pm); wr(8'h4A, cnt);
   endtask

   function automatic logic [15:0] rdmem(input int byte_addr);
      return mem.exists(byte_addr >> 1) ? mem[byte_addr >> 1] : 16'hXXXX;
   endfunction

   initial begin
      // Reset state
      repeat (3) step();
      chkreg("reset_data_out", 8'h4C, 16'h0000);
      check("reset_outputs", {27'd0, mem_req, akiko_sel, akiko_rd, busy, irq}, 32'd0);
      _reset = 1'b1;
      step();

      // Register readback, bit0 of byte quantities dropped
      wr(8'h40, 16'h1234); chkreg("src_h", 8'h40, 16'h0034);
      wr(8'h42, 16'h1001); chkreg("src_l", 8'h42, 16'h1000);
      wr(8'h48, 16'h0029); chkreg("pmod", 8'h48, 16'h0028);
      wr(8'h4A, 16'h0005); chkreg("count", 8'h4A, 16'h0005);
      address_in = 23'h5C0021; rd = 1'b1; sel_c2pdma = 1'b0; #1;
      check("unselected_read", {16'd0, data_out}, 32'd0);

      // Single group, zero-wait memory
      load_chunky(32'h1000, 8);
      for (int p = 0; p < 8; p++) mem[(32'h20000 + 40 * p) >> 1] = 16'hDEAD;
      setup(24'h001000, 24'h020000, 16'd40, 16'd1);
      n_rd = 0; n_wr = 0; n_push = 0; n_pull = 0;
      wr(8'h4C, 16'h0001);
      check("busy_after_start", {31'd0, busy}, 32'd1);
      wait_irq("job1_timeout", 400);
      check("job1_counts", {n_rd[7:0], n_push[7:0], n_pull[7:0], n_wr[7:0]}, 32'h08080808);
      check("job1_plane0", {16'd0, rdmem(32'h20000)}, 32'h5555);
      check("job1_plane1", {16'd0, rdmem(32'h20028)}, 32'h3333);
      check("job1_plane2", {16'd0, rdmem(32'h20050)}, 32'h0F0F);
      check("job1_plane3", {16'd0, rdmem(32'h20078)}, 32'h00FF);
      check("job1_plane7", {16'd0, rdmem(32'h20118)}, 32'h0000);
      chkreg("job1_ctrl", 8'h4C, 16'h4000);
      chkreg("job1_src_l", 8'h42, 16'h1010);
      chkreg("job1_dst_l", 8'h46, 16'h0002);
      chkreg("job1_count", 8'h4A, 16'h0000);

      // Three groups, one wait state; start+clear together; stray start while busy
      ack_delay = 1;
      load_chunky(32'h3000, 24);
      setup(24'h003000, 24'h040000, 16'd80, 16'd3);
      n_rd = 0; n_wr = 0; stab_err = 0;
      wr(8'h4C, 16'h0005);
      check("start_clr_irq", {30'd0, busy, irq}, 32'h2);
      repeat (20) step();
      wr(8'h4C, 16'h0001);
      wait_irq("job3_timeout", 1500);
      check("job3_counts", {n_rd[15:0], n_wr[15:0]}, {16'd24, 16'd24});
      check("job3_g0_plane3", {16'd0, rdmem(32'h400F0)}, 32'h00FF);
      check("job3_g1_plane4", {16'd0, rdmem(32'h40142)}, 32'hFFFF);
      check("job3_g2_plane0", {16'd0, rdmem(32'h40004)}, 32'h5555);
      check("job3_g2_plane5", {16'd0, rdmem(32'h40194)}, 32'hFFFF);
      chkreg("job3_src_l", 8'h42, 16'h3030);
      chkreg("job3_dst_l", 8'h46, 16'h0006);
      check("job3_stable", stab_err, 0);

      // COUNT=0 completes at once without touching the buses
      wr(8'h4C, 16'h0004);
      check("irq_cleared", {31'd0, irq}, 32'd0);
      wr(8'h4A, 16'h0000);
      n_act = 0;
      wr(8'h4C, 16'h0001);
      step();
      check("count0_irq", {31'd0, irq}, 32'd1);
      check("count0_no_activity", n_act, 0);

      // Abort during a slow STORE
      wr(8'h4C, 16'h0004);
      ack_delay = 5;
      for (int p = 0; p < 8; p++) mem[(32'h50000 + 40 * p) >> 1] = 16'hDEAD;
      setup(24'h001000, 24'h050000, 16'd40, 16'd1);
      n_wr = 0; stab_err = 0;
      wr(8'h4C, 16'h0001);
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 600; i++) begin
            if (mem_req && mem_we) begin seen = 1'b1; break; end
            step();
         end
         check("abort_store_seen", {31'd0, seen}, 32'd1);
      end
      wr(8'h4C, 16'h0002);
      check("abort_pending", {30'd0, busy, mem_req}, 32'h3);
      wait_idle("abort_timeout", 40);
      check("abort_state", {29'd0, busy, irq, mem_req}, 32'd0);
      check("abort_one_write", n_wr, 1);
      check("abort_write_done", {16'd0, rdmem(32'h50118)}, 32'h0000);
      check("abort_no_more", {16'd0, rdmem(32'h500F0)}, 32'hDEAD);
      check("abort_stable", stab_err, 0);
      chkreg("abort_src_l", 8'h42, 16'h1000);
      chkreg("abort_count", 8'h4A, 16'h0001);

      // Asynchronous reset in the middle of a FETCH, then a clean job
      ack_delay = 3;
      setup(24'h001000, 24'h060000, 16'd40, 16'd1);
      wr(8'h4C, 16'h0001);
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 50; i++) begin
            if (mem_req && !mem_we) begin seen = 1'b1; break; end
            step();
         end
         check("reset_fetch_seen", {31'd0, seen}, 32'd1);
      end
      _reset = 1'b0;
      #1;
      check("reset_async_outputs", {27'd0, mem_req, akiko_sel, akiko_rd, busy, irq}, 32'd0);
      chkreg("reset_regs", 8'h42, 16'h0000);
      step(); step();
      _reset = 1'b1;
      step();
      ack_delay = 0;
      setup(24'h001000, 24'h060000, 16'd40, 16'd1);
      wr(8'h4C, 16'h0001);
      wait_irq("post_reset_timeout", 400);
      check("post_reset_plane0", {16'd0, rdmem(32'h60000)}, 32'h5555);
      check("post_reset_plane3", {16'd0, rdmem(32'h60078)}, 32'h00FF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
